itype_stim_sequencer: RTL and testbench
=======================================

// Module: itype_stim_sequencer
// PURPOSE
//  Self-contained stimulus controller for the Sodor 5-stage I-type lockstep bench.
//  Sequencing: holds the core in reset, initialises both regfiles (model and RTL) through one write port,
//  streams NUM constrained-random OP-IMM instructions on the imem response channel, drains with NOPs, flags done.
//  Replaces free-running per-clock instruction generation with a deterministic, seed-reproducible, handshaked sequence.
// PARAMETERS
//  NUM_REGS    32            regfile entries initialised (indices 0..NUM_REGS-1)
//  WORD_SIZE   32            regfile data / instruction width
//  CNT_W       16            width of instruction counter and num_instrs
//  DRAIN_NOPS  5             NOP responses after last random instr (>= pipeline depth)
//  LFSR_TAPS   32'h80200003  right-shift Galois taps (x^32+x^22+x^2+x+1)
// PORTS
//  clk             in   1          clock, all state on posedge
//  reset           in   1          asynchronous, active-high
//  start           in   1          begin sequence; sampled in IDLE/DONE only
//  seed_load       in   1          load seed into LFSR; honoured in IDLE only
//  seed            in   32         LFSR seed; 0 is replaced by 1
//  num_instrs      in   CNT_W      random instructions to issue
//  imem_req_valid  in   1          core fetch request this cycle
//  imem_resp_valid out  1          response valid (1-cycle latency)
//  imem_resp_data  out  WORD_SIZE  instruction word
//  rf_wr_en        out  1          regfile init write strobe
//  rf_wr_addr      out  5          regfile init index
//  rf_wr_data      out  WORD_SIZE  regfile init value
//  core_reset      out  1          reset to core under test
//  busy            out  1          high in INIT/RUN/DRAIN
//  done            out  1          high in DONE
//  instr_count     out  CNT_W      random instrs issued this sequence
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, lfsr=1, core_reset=1, imem_resp_data=32'h00000013,
//   all other outputs 0. Mid-sequence reset aborts; no partial-state retention.
//  LFSR step: lfsr <= lfsr[0] ? (lfsr>>1)^LFSR_TAPS : lfsr>>1. Advances only per init write and per random instr.
//  IDLE: core_reset=1. seed_load -> lfsr<=(seed==0)?1:seed. start -> INIT, idx=0, instr_count=0.
//   seed_load and start in the same cycle: seed loads first, INIT uses the new seed.
//  INIT: NUM_REGS cycles; cycle i: rf_wr_en=1, addr=i, data=stepped lfsr value (registered outputs).
//   core_reset stays 1; imem_req_valid ignored. After index NUM_REGS-1 -> RUN
//   (num_instrs==0 -> DRAIN directly).
//  RUN: core_reset=0. On imem_req_valid at cycle t: cycle t+1 imem_resp_valid=1,
//   imem_resp_data={imm,rs1,funct3,rd,7'b0010011} from stepped w:
//   imm=w[31:20], rs1=w[19:15], funct3=w[14:12], rd=w[11:7];
//   funct3==3'd5: imm&=12'h41F (SRLI/SRAI); funct3==3'd1: imm&=12'h01F (SLLI).
//   instr_count++ per response; when it reaches num_instrs -> DRAIN.
//   No request -> imem_resp_valid=0, data holds last value.
//  DRAIN: each request answered next cycle with 32'h00000013 (valid=1), lfsr frozen;
//   after DRAIN_NOPS NOPs -> DONE.
//  DONE: done=1, busy=0, core_reset=0, requests answered with NOP.
//   start -> INIT (lfsr continues; no reseed). num_instrs sampled at start; later changes ignored.
//  busy/done mutually exclusive; instr_count saturates at num_instrs, never wraps.
// TESTING
//  T1 seed=0,seed_load,start: first writes addr0=32'h80200003, addr1=32'hC0300002; core_reset=1 for 32 writes.
//  T2 num_instrs=4, req every cycle: exactly 4 OP-IMM words (opcode 7'h13), then 5 NOPs, done=1, instr_count=4.
//  T3 force funct3=5/1 via seed sweep: imm&~12'h41F==0 for 5, imm[11:5]==0 for 1; other funct3 unmasked.
//  T4 sparse req (1 in 3 cycles): responses exactly 1 cycle after each request, none otherwise.
//  T5 num_instrs=0: INIT -> DRAIN -> DONE; no random word emitted, instr_count=0.
//  T6 reset asserted mid-RUN (count=2): outputs reset immediately (async), core_reset=1;
//     restart with same seed reproduces identical stream.

Source files
------------

// File: rtl/itype_stim_sequencer_if.sv
// Instruction-memory response channel and regfile-init write port shared by
// the stimulus sequencer and the lockstep bench.
interface itype_stim_sequencer_if #(
    parameter int unsigned WORD_SIZE = 32
);
    logic                 imem_req_valid;
    logic                 imem_resp_valid;
    logic [WORD_SIZE-1:0] imem_resp_data;
    logic                 rf_wr_en;
    logic [4:0]           rf_wr_addr;
    logic [WORD_SIZE-1:0] rf_wr_data;

    modport master (
        input  imem_req_valid,
        output imem_resp_valid,
        output imem_resp_data,
        output rf_wr_en,
        output rf_wr_addr,
        output rf_wr_data
    );

    modport slave (
        output imem_req_valid,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  rf_wr_en,
        input  rf_wr_addr,
        input  rf_wr_data
    );
endinterface

// File: rtl/itype_stim_sequencer.sv
// Deterministic OP-IMM stimulus sequencer: regfile init, seeded random I-type
// stream on the imem response channel, NOP drain, done.
module itype_stim_sequencer #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned DRAIN_NOPS = 5,
    parameter logic [31:0] LFSR_TAPS  = 32'h80200003
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 seed_load,
    input  logic [31:0]          seed,
    input  logic [CNT_W-1:0]     num_instrs,
    itype_stim_sequencer_if.master bus,
    output logic                 core_reset,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     instr_count
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam int unsigned    IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned    NOP_W    = $clog2(DRAIN_NOPS + 1);
    localparam logic [31:0]    NOP      = 32'h00000013;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [NOP_W-1:0] LAST_NOP = NOP_W'(DRAIN_NOPS - 1);

    state_e               state_q;
    logic [31:0]          lfsr_q;
    logic [31:0]          lfsr_d;
    logic [31:0]          seed_d;
    logic [31:0]          instr_d;
    logic [11:0]          imm_mask;
    logic [IDX_W-1:0]     idx_q;
    logic [NOP_W-1:0]     nop_cnt_q;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     target_q;
    logic                 core_reset_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 resp_valid_q;
    logic [WORD_SIZE-1:0] resp_data_q;
    logic                 rf_wr_en_q;
    logic [4:0]           rf_wr_addr_q;
    logic [WORD_SIZE-1:0] rf_wr_data_q;

    always_comb begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        seed_d = (seed == '0) ? 32'd1 : seed;
        // Shift-immediate encodings keep only shamt (and bit 30 for SRAI).
        unique case (lfsr_d[14:12])
            3'd5:    imm_mask = 12'h41F;
            3'd1:    imm_mask = 12'h01F;
            default: imm_mask = 12'hFFF;
        endcase
        // Fields stay in place; only imm is masked and the opcode forced to OP-IMM.
        instr_d = (lfsr_d & {imm_mask, 20'hFFF80}) | NOP;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lfsr_q       <= 32'd1;
            idx_q        <= '0;
            nop_cnt_q    <= '0;
            count_q      <= '0;
            target_q     <= '0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= WORD_SIZE'(NOP);
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_data_q <= '0;
        end else begin
            rf_wr_en_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    core_reset_q <= 1'b1;
                    if (seed_load) begin
                        lfsr_q <= seed_d;
                    end
                    if (start) begin
                        state_q  <= S_INIT;
                        idx_q    <= '0;
                        count_q  <= '0;
                        target_q <= num_instrs;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end
                end
                S_INIT: begin
                    rf_wr_en_q   <= 1'b1;
                    rf_wr_addr_q <= 5'(idx_q);
                    rf_wr_data_q <= WORD_SIZE'(lfsr_d);
                    lfsr_q       <= lfsr_d;
                    idx_q        <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        nop_cnt_q <= '0;
                        state_q   <= (target_q == '0) ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    core_reset_q <= 1'b0;
                    if (bus.imem_req_valid) begin
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= WORD_SIZE'(instr_d);
                        lfsr_q       <= lfsr_d;
                        count_q      <= count_q + 1'b1;
                        if ((count_q + 1'b1) == target_q) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    core_reset_q <= 1'b0;
                    if (bus.imem_req_valid) begin
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= WORD_SIZE'(NOP);
                        nop_cnt_q    <= nop_cnt_q + 1'b1;
                        if (nop_cnt_q == LAST_NOP) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        // Restart continues the LFSR; the core goes back under reset for init.
                        state_q      <= S_INIT;
                        idx_q        <= '0;
                        count_q      <= '0;
                        target_q     <= num_instrs;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        core_reset_q <= 1'b1;
                    end else begin
                        core_reset_q <= 1'b0;
                        if (bus.imem_req_valid) begin
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= WORD_SIZE'(NOP);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.imem_resp_valid = resp_valid_q;
    assign bus.imem_resp_data  = resp_data_q;
    assign bus.rf_wr_en        = rf_wr_en_q;
    assign bus.rf_wr_addr      = rf_wr_addr_q;
    assign bus.rf_wr_data      = rf_wr_data_q;
    assign core_reset          = core_reset_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign instr_count         = count_q;
endmodule

// File: tb/tb_itype_stim_sequencer.sv
// Scoreboard bench for itype_stim_sequencer: the driver queues expected regfile
// writes and imem responses, a negedge monitor pops and compares them.
module tb_itype_stim_sequencer;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned DRAIN_NOPS = 5;
    localparam logic [31:0] TAPS       = 32'h80200003;
    localparam logic [31:0] NOP        = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        seed_load = 1'b0;
    logic [31:0] seed = '0;
    logic [15:0] num_instrs = '0;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic [15:0] instr_count;

    itype_stim_sequencer_if #(.WORD_SIZE(32)) bus ();

    itype_stim_sequencer #(
        .NUM_REGS   (NUM_REGS),
        .WORD_SIZE  (32),
        .CNT_W      (16),
        .DRAIN_NOPS (DRAIN_NOPS),
        .LFSR_TAPS  (TAPS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .seed_load   (seed_load),
        .seed        (seed),
        .num_instrs  (num_instrs),
        .bus         (bus),
        .core_reset  (core_reset),
        .busy        (busy),
        .done        (done),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } rfw_t;

    rfw_t        exp_rf[$];
    logic [31:0] exp_resp[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] m_lfsr = 32'd1;
    bit          m_idle = 1'b1;
    bit          mon_en = 1'b0;
    bit          t1_active = 1'b0;
    bit          chk_timing = 1'b0;
    logic        req_d = 1'b0;
    int          f3_5_seen = 0;
    int          f3_1_seen = 0;
    rfw_t        mon_e;
    logic [31:0] mon_w;
    logic [2:0]  mon_f3;
    logic [11:0] mon_imm;

    initial bus.imem_req_valid = 1'b0;

    function automatic logic [31:0] step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
    endfunction

    function automatic logic [31:0] fmt(input logic [31:0] w);
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        logic [2:0]  f3;
        imm = w[31:20];
        rs1 = w[19:15];
        f3  = w[14:12];
        rd  = w[11:7];
        if (f3 == 3'd5)      imm = imm & 12'h41F;
        else if (f3 == 3'd1) imm = imm & 12'h01F;
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) req_d <= bus.imem_req_valid;

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            check("busy_done_excl", 32'(busy & done), 32'd0);
            if (bus.rf_wr_en) begin
                if (exp_rf.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rf_unexpected: got write addr %0d, want none", bus.rf_wr_addr);
                end else begin
                    mon_e = exp_rf.pop_front();
                    check("rf_addr", 32'(bus.rf_wr_addr), 32'(mon_e.addr));
                    check("rf_data", bus.rf_wr_data, mon_e.data);
                end
                check("rf_core_reset", 32'(core_reset), 32'd1);
                if (t1_active && bus.rf_wr_addr == 5'd0) check("t1_addr0", bus.rf_wr_data, 32'h80200003);
                if (t1_active && bus.rf_wr_addr == 5'd1) check("t1_addr1", bus.rf_wr_data, 32'hC0300002);
            end
            if (bus.imem_resp_valid) begin
                if (exp_resp.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got 0x%08h, want no response", bus.imem_resp_data);
                end else begin
                    mon_w = exp_resp.pop_front();
                    check("resp_data", bus.imem_resp_data, mon_w);
                end
                check("resp_opcode", 32'(bus.imem_resp_data[6:0]), 32'h13);
                mon_f3  = bus.imem_resp_data[14:12];
                mon_imm = bus.imem_resp_data[31:20];
                if (mon_f3 == 3'd5) begin
                    f3_5_seen++;
                    check("srli_imm_mask", 32'(mon_imm & ~12'h41F), 32'd0);
                end
                if (mon_f3 == 3'd1) begin
                    f3_1_seen++;
                    check("slli_imm_mask", 32'(mon_imm[11:5]), 32'd0);
                end
            end
            if (chk_timing) check("resp_timing", 32'(bus.imem_resp_valid), 32'(req_d));
        end
    end

    // Asserts reset mid-cycle so the asynchronous clear is observed before any edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_resp_valid", 32'(bus.imem_resp_valid), 32'd0);
        check("rst_resp_data", bus.imem_resp_data, NOP);
        check("rst_rf_wr_en", 32'(bus.rf_wr_en), 32'd0);
        check("rst_rf_wr_addr", 32'(bus.rf_wr_addr), 32'd0);
        check("rst_rf_wr_data", bus.rf_wr_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_instr_count", 32'(instr_count), 32'd0);
        start = 1'b0;
        seed_load = 1'b0;
        bus.imem_req_valid = 1'b0;
        exp_rf.delete();
        exp_resp.delete();
        m_lfsr = 32'd1;
        m_idle = 1'b1;
        chk_timing = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_seq(input logic [31:0] s, input bit load, input int num,
                           input int gap, input int max_req, input bit timing);
        int total;
        int k;
        total = num + DRAIN_NOPS + 1;
        if (max_req >= 0 && max_req < total) total = max_req;
        seed       = s;
        seed_load  = load;
        num_instrs = 16'(num);
        start      = 1'b1;
        if (load && m_idle) m_lfsr = (s == 32'd0) ? 32'd1 : s;
        m_idle = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            m_lfsr = step(m_lfsr);
            exp_rf.push_back(rfw_t'({5'(i), m_lfsr}));
        end
        tick();
        start      = 1'b0;
        seed_load  = 1'b0;
        num_instrs = 16'(num + 7);
        k = 0;
        while (core_reset !== 1'b0 && k < 200) begin
            tick();
            k++;
        end
        check("core_release", 32'(core_reset), 32'd0);
        check("rf_init_all_written", 32'(exp_rf.size()), 32'd0);
        chk_timing = timing;
        for (int r = 0; r < total; r++) begin
            bus.imem_req_valid = 1'b1;
            if (r < num) begin
                m_lfsr = step(m_lfsr);
                exp_resp.push_back(fmt(m_lfsr));
            end else begin
                exp_resp.push_back(NOP);
            end
            tick();
            bus.imem_req_valid = 1'b0;
            repeat (gap) tick();
        end
        repeat (2) tick();
        check("resp_drained", 32'(exp_resp.size()), 32'd0);
        if (total == num + DRAIN_NOPS + 1) begin
            check("seq_done", 32'(done), 32'd1);
            check("seq_busy", 32'(busy), 32'd0);
            check("seq_instr_count", 32'(instr_count), 32'(num));
            check("seq_core_reset", 32'(core_reset), 32'd0);
        end
        chk_timing = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();
        mon_en = 1'b1;

        t1_active = 1'b1;
        run_seq(32'h0, 1'b1, 4, 0, -1, 1'b0);
        t1_active = 1'b0;

        run_seq(32'hDEADBEEF, 1'b1, 6, 2, -1, 1'b1);
        run_seq(32'h00000001, 1'b0, 0, 0, -1, 1'b1);

        do_reset();
        run_seq(32'h12345678, 1'b1, 64, 0, -1, 1'b0);
        do_reset();
        run_seq(32'h0BADF00D, 1'b1, 40, 1, -1, 1'b1);

        do_reset();
        run_seq(32'hCAFEF00D, 1'b1, 4, 0, 2, 1'b0);
        check("t6_count_mid_run", 32'(instr_count), 32'd2);
        check("t6_busy_mid_run", 32'(busy), 32'd1);
        do_reset();
        run_seq(32'hCAFEF00D, 1'b1, 4, 0, -1, 1'b0);

        check("cov_funct3_5", 32'(f3_5_seen > 0), 32'd1);
        check("cov_funct3_1", 32'(f3_1_seen > 0), 32'd1);
        check("final_rf_queue", 32'(exp_rf.size()), 32'd0);
        check("final_resp_queue", 32'(exp_resp.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
